// File: rtl/fetch_queue_pkg.sv
// Shared defaults for the fetch queue and the stages that must agree with it
// (decode and branch resolution use the same PC width and reset vector).
package fetch_queue_pkg;

    localparam int unsigned FQ_PC_W     = 30;
    localparam int unsigned FQ_DATA_W   = 32;
    localparam int unsigned FQ_DEPTH    = 4;
    localparam int unsigned FQ_RESET_PC = 0;

    // Counters must hold the value DEPTH itself, hence the extra bit.
    function automatic int unsigned fq_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, ir} pairs between memory return and decode.
// Head data is read combinationally from storage through a registered pointer.
// Flush empties the queue in one cycle and overrides push and pop.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int unsigned WIDTH = 62,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = fq_cnt_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && (count_q != '0);

    // Pointer and occupancy next-state; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; entries are only visible once counted.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // The issue side reserves space before requesting, so a full push is a bug.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        do_push |-> (count_q != FULL) || do_pop);

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: issues in-order word reads to a pipelined instruction memory,
// keeps up to DEPTH reads in flight, queues the returned words and hands
// {pc, ir} to decode. A redirect flushes the queue and marks every read still
// in flight as stale so its response is dropped on arrival.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned      PC_W     = FQ_PC_W,
    parameter int unsigned      DATA_W   = FQ_DATA_W,
    parameter int unsigned      DEPTH    = FQ_DEPTH,
    parameter logic [PC_W-1:0]  RESET_PC = PC_W'(FQ_RESET_PC)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              take_branch_i,
    input  logic [PC_W-1:0]   branch_pc_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] ir_o,
    output logic [PC_W-1:0]   pc_o,
    output logic              req_o,
    output logic [PC_W-1:0]   addr_o,
    input  logic              gnt_i,
    input  logic              rvalid_i,
    input  logic [DATA_W-1:0] rdata_i
);

    localparam int unsigned      CNT_W   = fq_cnt_w(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_X = (CNT_W + 1)'(DEPTH);

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   in_flight;
    logic             grant;
    logic             resp;
    logic             push;
    logic             pop;

    // Live words: buffered plus requested-and-still-wanted. Stale reads do
    // not occupy queue space because their data never lands.
    assign in_flight = {1'b0, fifo_count} + {1'b0, outst_q} - {1'b0, drop_q};

    assign req_o   = !rst_i && !take_branch_i && (in_flight < DEPTH_X);
    assign addr_o  = fetch_pc_q;
    assign grant   = req_o && gnt_i;
    assign resp    = rvalid_i && (outst_q != '0);
    assign push    = resp && (drop_q == '0) && !take_branch_i;
    assign valid_o = (fifo_count != '0);
    assign pop     = valid_o && !stall_i && !take_branch_i;

    fetch_fifo #(
        .WIDTH (PC_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (take_branch_i),
        .wdata_i ({resp_pc_q, rdata_i}),
        .head_o  ({pc_o, ir_o}),
        .count_o (fifo_count)
    );

    // PC and counter next-state; a redirect overrides normal advance.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;

        case ({grant, resp})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase

        if (take_branch_i) begin
            fetch_pc_d = branch_pc_i;
            resp_pc_d  = branch_pc_i;
            // Everything still outstanding after this cycle belongs to the
            // abandoned path.
            drop_d     = outst_d;
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + PC_W'(1);
            if (push)  resp_pc_d  = resp_pc_q + PC_W'(1);
            if (resp && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
        end
    end

    // PC and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
        end
    end

    a_drop_le_outst: assert property (@(posedge clk_i) disable iff (rst_i)
        drop_q <= outst_q);

    a_in_flight_le_depth: assert property (@(posedge clk_i) disable iff (rst_i)
        in_flight <= DEPTH_X);

    a_rvalid_with_outst: assert property (@(posedge clk_i) disable iff (rst_i)
        !(rvalid_i && (outst_q == '0)));

    a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (req_o && !gnt_i) |=> take_branch_i || (addr_o == $past(addr_o)));

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int PC_W   = 30;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              stall_i;
    logic              take_branch_i;
    logic [PC_W-1:0]   branch_pc_i;
    logic              valid_o;
    logic [DATA_W-1:0] ir_o;
    logic [PC_W-1:0]   pc_o;
    logic              req_o;
    logic [PC_W-1:0]   addr_o;
    logic              gnt_i;
    logic              rvalid_i;
    logic [DATA_W-1:0] rdata_i;

    fetch_queue #(
        .PC_W     (PC_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC ('0)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .take_branch_i (take_branch_i),
        .branch_pc_i   (branch_pc_i),
        .valid_o       (valid_o),
        .ir_o          (ir_o),
        .pc_o          (pc_o),
        .req_o         (req_o),
        .addr_o        (addr_o),
        .gnt_i         (gnt_i),
        .rvalid_i      (rvalid_i),
        .rdata_i       (rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [PC_W-1:0] pc; logic [DATA_W-1:0] ir; } exp_t;
    typedef struct { logic [PC_W-1:0] addr; int ready; } pend_t;

    exp_t  exp_q[$];    // live words decode must still receive, oldest first
    pend_t pend_q[$];   // memory-side pending reads (includes stale ones)

    int cyc = 0;
    int chk_cnt = 0;
    int pass_cnt = 0;
    int gnt_mode = 0;   // 0 never, 1 always, 2 random
    bit hold = 1'b0;
    int lat_max = 1;
    int stall_pct = 0;
    int br_pct = 0;
    bit force_br = 1'b0;
    logic [PC_W-1:0] force_pc = '0;
    logic [PC_W-1:0] model_pc = '0;
    bit prev_br = 1'b0;
    int grants = 0;
    bit wrap_zero = 1'b0;

    function automatic logic [DATA_W-1:0] mem_word(input logic [PC_W-1:0] a);
        return {a[13:0], a[29:12]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Stimulus driver and memory response side.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            cyc++;
            if (rst_i) begin
                gnt_i = 1'b0;
                rvalid_i = 1'b0;
                take_branch_i = 1'b0;
                stall_i = 1'b0;
            end else begin
                stall_i = ($urandom_range(99) < stall_pct);
                take_branch_i = 1'b0;
                if (force_br) begin
                    take_branch_i = 1'b1;
                    branch_pc_i = force_pc;
                    force_br = 1'b0;
                end else if ($urandom_range(99) < br_pct) begin
                    take_branch_i = 1'b1;
                    if ($urandom_range(1) == 1) branch_pc_i = PC_W'($urandom);
                    else branch_pc_i = 30'h3FFF_FFFC + PC_W'($urandom_range(3));
                end
                if (gnt_mode == 1) gnt_i = 1'b1;
                else if (gnt_mode == 2) gnt_i = ($urandom_range(1) == 1);
                else gnt_i = 1'b0;
                rvalid_i = 1'b0;
                if (!hold && pend_q.size() > 0 && pend_q[0].ready <= cyc &&
                    (lat_max == 1 || $urandom_range(3) != 0)) begin
                    rvalid_i = 1'b1;
                    rdata_i = mem_word(pend_q[0].addr);
                    void'(pend_q.pop_front());
                end
            end
        end
    end

    // Issue-side reference: request gating, address sequence, expected pushes.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                prev_br = 1'b0;
            end else begin
                if (prev_br) chk("valid_after_redirect", valid_o, 0);
                chk("req_o", req_o, !take_branch_i && (exp_q.size() < DEPTH));
                if (req_o) chk("addr_o", addr_o, model_pc);
                if (take_branch_i) begin
                    exp_q.delete();
                    model_pc = branch_pc_i;
                end else if (req_o && gnt_i) begin
                    pend_q.push_back('{addr_o, cyc + ((lat_max == 1) ? 1 : int'($urandom_range(lat_max, 1)))});
                    exp_q.push_back('{model_pc, mem_word(model_pc)});
                    if (addr_o == '0) wrap_zero = 1'b1;
                    model_pc = model_pc + 30'd1;
                    grants++;
                end
                prev_br = take_branch_i;
            end
        end
    end

    // Monitor: every word decode accepts must be the oldest live expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #1;
            if (!rst_i && valid_o && !stall_i && !take_branch_i) begin
                if (exp_q.size() == 0) begin
                    chk("valid_unexpected", valid_o, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pc_o", pc_o, e.pc);
                    chk("ir_o", ir_o, e.ir);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        rvalid_i = 1'b0;
        gnt_i = 1'b0;
        take_branch_i = 1'b0;
        stall_i = 1'b0;
        force_br = 1'b0;
        pend_q.delete();
        exp_q.delete();
        model_pc = '0;
        @(negedge clk_i);
        chk("reset_valid", valid_o, 0);
        chk("reset_req", req_o, 0);
        chk("reset_addr", addr_o, 0);
        @(posedge clk_i);
        #2;
        grants = 0;
        wrap_zero = 1'b0;
        rst_i = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && (exp_q.size() != 0 || pend_q.size() != 0); i++) @(posedge clk_i);
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        int first_g;
        int first_v;
        rst_i = 1'b1;
        stall_i = 1'b0;
        take_branch_i = 1'b0;
        branch_pc_i = '0;
        gnt_i = 1'b0;
        rvalid_i = 1'b0;
        rdata_i = '0;

        // Streaming from reset: grant every cycle, 1-cycle latency.
        gnt_mode = 1;
        lat_max = 1;
        do_reset();
        first_g = -1;
        first_v = -1;
        for (int i = 0; i < 20 && first_v < 0; i++) begin
            @(negedge clk_i);
            #2;
            if (first_g < 0 && req_o && gnt_i) first_g = cyc;
            if (valid_o) first_v = cyc;
        end
        chk("first_valid_latency", first_v - first_g, 2);
        repeat (30) @(posedge clk_i);

        // Responses held off: exactly DEPTH grants, then request stops.
        hold = 1'b1;
        do_reset();
        repeat (20) @(posedge clk_i);
        chk("holdoff_grants", grants, DEPTH);
        @(negedge clk_i);
        chk("holdoff_req", req_o, 0);

        // Decode stalled while responses flow: queue fills, then drains in order.
        @(posedge clk_i);
        #2;
        stall_pct = 100;
        hold = 1'b0;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        chk("stall_full_req", req_o, 0);
        chk("stall_full_valid", valid_o, 1);
        @(posedge clk_i);
        #2;
        stall_pct = 0;
        repeat (30) @(posedge clk_i);

        // Redirect with three reads in flight; stale words must vanish.
        #2;
        gnt_mode = 0;
        drain("drain_before_redirect");
        @(posedge clk_i);
        #2;
        hold = 1'b1;
        gnt_mode = 1;
        repeat (3) @(posedge clk_i);
        #2;
        gnt_mode = 0;
        force_pc = 30'h100;
        force_br = 1'b1;
        repeat (3) @(posedge clk_i);
        #2;
        chk("stale_outstanding", pend_q.size(), 3);
        hold = 1'b0;
        gnt_mode = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            #2;
            if (valid_o) begin
                chk("redirect_first_pc", pc_o, 30'h100);
                break;
            end
        end
        repeat (20) @(posedge clk_i);

        // PC wrap at the top of the address space.
        #2;
        wrap_zero = 1'b0;
        force_pc = 30'h3FFF_FFFE;
        force_br = 1'b1;
        repeat (20) @(posedge clk_i);
        chk("wrap_to_zero", wrap_zero, 1);

        // Randomised traffic with redirects, stalls and variable latency.
        #2;
        gnt_mode = 2;
        lat_max = 4;
        stall_pct = 30;
        br_pct = 5;
        repeat (3000) @(posedge clk_i);
        #2;
        br_pct = 0;
        stall_pct = 0;
        gnt_mode = 0;
        drain("final_drain");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-register fetch stage.
- Decouples the PC generator from a pipelined, in-order instruction memory.
- Supports up to DEPTH outstanding reads, buffers returned words in a DEPTH-entry queue, and delivers {pc, ir} pairs to decode with a valid/stall handshake.
- Branch redirects flush the queue and silently discard in-flight responses.

Parameters:
PC_W, 30, word-address width of the PC and memory address
DATA_W, 32, instruction word width
DEPTH, 4, queue entries and maximum outstanding reads (power of 2, >=2)
RESET_PC, 0, first word address fetched after reset

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  asynchronous, active-high reset
stall_i  in  1  decode cannot accept this cycle
take_branch_i  in  1  one-cycle redirect pulse from a later stage
branch_pc_i  in  PC_W  redirect target word address
valid_o  out  1  ir_o/pc_o hold a valid instruction
ir_o  out  DATA_W  instruction at head of queue
pc_o  out  PC_W  word address of ir_o
req_o  out  1  memory read request
addr_o  out  PC_W  read word address
gnt_i  in  1  memory accepted the request this cycle
rvalid_i  in  1  read data returned (in order, >=1 cycle after grant)
rdata_i  in  DATA_W  returned word

Behaviour:
- Reset (async assert, sync-safe release):
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - Queue count=0, outstanding=0, drop=0.
  - valid_o=0, req_o=0; ir_o and pc_o are don't-care.
- Reset mid-operation: all state cleared immediately. Responses to pre-reset grants are the memory's responsibility to squash; the block ignores rvalid_i while outstanding==0.
- Issue:
  - req_o = !take_branch_i && (count + outstanding - drop) < DEPTH.
  - addr_o = fetch_pc.
  - req_o && gnt_i: fetch_pc <= fetch_pc+1 (wraps mod 2^PC_W), outstanding+1.
  - req_o may stay high back-to-back; addr_o must not change while req_o=1 and gnt_i=0.
- Response: rvalid_i, outstanding-1. Then:
  - drop>0: discard the word, drop-1.
  - otherwise: push {resp_pc, rdata_i}, resp_pc+1.
  - Space is always available because of the issue-side reservation.
- Output:
  - valid_o = count!=0; ir_o/pc_o driven from the queue head.
  - Pop when valid_o && !stall_i.
  - No bypass: rvalid_i at cycle N gives valid_o at N+1 at the earliest.
  - Push and pop in the same cycle leave count unchanged.
- Redirect (take_branch_i=1), highest priority:
  - Queue flushed: count=0, and valid_o=0 next cycle.
  - fetch_pc and resp_pc <= branch_pc_i.
  - drop <= outstanding after this cycle's grant/response accounting. A grant cannot occur because req_o=0.
  - A response arriving in the same cycle is discarded and counted against outstanding.
  - A pop in the same cycle has no effect beyond the flush.
  - First post-redirect request is issued the next cycle.
- Back-to-back redirects: each one re-targets; drop accumulates to the current outstanding.
- Widths:
  - count, outstanding and drop are $clog2(DEPTH)+1 bits.
  - Invariants: drop <= outstanding and count + outstanding - drop <= DEPTH. Both carry simulation assertions.
- Protocol violation: rvalid_i with outstanding==0 is ignored, and a simulation assertion fires.

Decomposition:
- Shared defines.v additions:
  - PC_W and DATA_W defaults.
  - RESET_PC default, so fetch_queue and the decode/branch stages agree.
- Sub-module fetch_fifo:
  - Synchronous DEPTH x (PC_W+DATA_W) FIFO with push, pop and flush.
  - Registered read pointer, head data combinational from storage.
- fetch_queue holds:
  - fetch_pc, resp_pc and the outstanding/drop counters.
  - Issue gating and redirect logic.

Test Plan:
- Reset release, memory gnt_i=1 with 1-cycle rvalid latency, stall_i=0 -> addr_o 0,1,2,3...; valid_o first high 2 cycles after first grant; pc_o 0,1,2 with the matching rdata_i.
- Memory grants every cycle, responses held off, DEPTH=4 -> exactly 4 grants (addr 0..3), then req_o=0 until a response returns; no overflow.
- stall_i=1 for 10 cycles with responses flowing -> queue fills to 4, req_o drops; release -> pc_o 0..3 in order, then fetch resumes at 4.
- 3 reads outstanding (addr 5,6,7), take_branch_i with branch_pc_i=0x100 -> next req addr_o=0x100; the 3 stale words are discarded; first valid_o shows pc_o=0x100.
- Redirect in the same cycle as an rvalid_i and a pop -> that word is dropped, drop = remaining outstanding, valid_o=0 next cycle.
- fetch_pc=2^30-1 -> next addr_o=0, pc_o wraps to 0; no spurious valid_o.
